bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master, one-slave arbiter for the core's pulse-begin/pulse-end memory bus. It shares a single memory/register-file port between the CPU (master 0) and a second requester such as debug or DMA (master 1). Each master's begin pulse is captured into a request slot, slots are granted round-robin, and one transaction is forwarded to the slave at a time. The completion pulse and read data are routed back to the owning master, and a watchdog terminates slave transactions that never complete.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, slave wait limit in cycles; 0 disables the watchdog.
- ERROR_DATA, 32'hDEADBEEF, read data returned to the master on timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0Address / m1Address  in  32  request address.
- m0DataOut / m1DataOut  in  32  write data.
- m0WriteEnable / m1WriteEnable  in  1  write (1) or read (0).
- m0WriteMask / m1WriteMask  in  4  byte lanes: 1 = byte, 3 = half, 15 = word.
- m0TransactionBegin / m1TransactionBegin  in  1  one-cycle request pulse; all fields valid in the same cycle.
- m0DataIn / m1DataIn  out  32  read data; valid while the matching end pulse is high.
- m0TransactionEnd / m1TransactionEnd  out  1  one-cycle completion pulse.
- sAddress, sDataOut, sWriteEnable, sWriteMask  out  32/32/1/4  forwarded request fields.
- sTransactionBegin  out  1  one-cycle pulse to the slave.
- sDataIn  in  32  slave read data.
- sTransactionEnd  in  1  slave completion pulse.
- timeoutError  out  1  sticky; set on any watchdog expiry.
- overrunError  out  1  sticky; set when a begin arrives while that master's slot is already pending.

## Operation
- Request slot per master:
  - A begin pulse with the slot empty latches address, data, writeEnable and writeMask, and sets pending.
  - A begin pulse with the slot already pending is dropped and sets overrunError.
- FSM states are IDLE and WAIT.
- IDLE:
  - If any slot is pending, grant it, drive the slave fields from that slot, pulse sTransactionBegin for one cycle, load the watchdog, and go to WAIT.
  - If both slots are pending, grant the master not granted last. lastGrant resets to 1, so m0 wins the first tie.
- WAIT:
  - On sTransactionEnd: register sDataIn into the granted master's DataIn, pulse its TransactionEnd for one cycle, clear its pending bit, update lastGrant, and go to IDLE.
  - If the watchdog reaches 0 first (TIMEOUT_CYCLES != 0): return ERROR_DATA with an end pulse, set timeoutError, clear pending, and go to IDLE.
- sTransactionEnd seen in IDLE (late response after a timeout) is ignored.
- The non-granted master's DataIn holds its last value, and its end pulse stays low.
- Slave output fields hold their last granted values between transactions.
- Reset values: all outputs 0, state IDLE, both slots empty, lastGrant = 1, error flags 0.

## Timing
- Begin is captured at edge N. sTransactionBegin is high during cycle N+1 when the arbiter is idle.
- Slave end sampled at edge M: master end and DataIn are high/valid during cycle M+1.
- Minimum round trip is the slave latency plus 2 cycles.
- The watchdog counts cycles in WAIT. Expiry fires on the TIMEOUT_CYCLES-th WAIT cycle without an end.
- sTransactionEnd and watchdog expiry in the same cycle: the slave response wins and timeoutError is not set.
- A master begin and its own completion in the same cycle: the new request is captured, since the slot frees at that same edge. No overrun.
- The other master's begin during WAIT is captured and served in the next IDLE cycle, so back-to-back transactions have a 1-cycle gap.
- Reset asserted mid-transaction: abort immediately, send no end pulse, and discard pending requests.

## Structure
- Shared package holds:
  - state encoding (IDLE, WAIT);
  - ERROR_DATA default;
  - mask constants BYTE_MASK = 1, HALF_MASK = 3, WORD_MASK = 15;
  - register-file window base 32'hE0000000.
- Sub-module bus_request_slot: one capture register plus pending flag and overrun detect, instantiated twice.

## Test plan
- Single m0 read of 0x100, slave returns 0x12345678 after 3 cycles -> m0TransactionEnd pulses once with m0DataIn = 0x12345678; sTransactionBegin high exactly one cycle; m1 outputs unchanged.
- m0 and m1 begin in the same cycle (m0 read 0x0, m1 write 0xA5A5A5A5 to 0x40, mask 15) -> m0 served first, then m1; slave sees the correct fields for each; then m0 and m1 again simultaneously -> m1 granted first.
- m1 write with mask 1 while m0 is in WAIT -> m1 captured, issued one cycle after m0 completes, sWriteMask = 1.
- Slave never responds, TIMEOUT_CYCLES = 8 -> master end after 8 WAIT cycles with DataIn = 0xDEADBEEF and timeoutError = 1; a late sTransactionEnd is ignored.
- m0 pulses begin twice while pending -> overrunError = 1; only the first request reaches the slave.
- rst low during WAIT -> all outputs 0 and no end pulses; after release, a new request is served normally.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    localparam logic [31:0] ERROR_DATA_DEFAULT = 32'hDEADBEEF;

    localparam logic [3:0]  BYTE_MASK = 4'd1;
    localparam logic [3:0]  HALF_MASK = 4'd3;
    localparam logic [3:0]  WORD_MASK = 4'd15;

    localparam logic [31:0] REGFILE_BASE = 32'hE0000000;

endpackage

// File: rtl/bus_arbiter_if.sv
// Pulse-begin/pulse-end bus bundle: two master ports, one slave port, error flags.
interface bus_arbiter_if;

    logic [31:0] m0Address, m0DataOut, m0DataIn;
    logic        m0WriteEnable, m0TransactionBegin, m0TransactionEnd;
    logic [3:0]  m0WriteMask;

    logic [31:0] m1Address, m1DataOut, m1DataIn;
    logic        m1WriteEnable, m1TransactionBegin, m1TransactionEnd;
    logic [3:0]  m1WriteMask;

    logic [31:0] sAddress, sDataOut, sDataIn;
    logic        sWriteEnable, sTransactionBegin, sTransactionEnd;
    logic [3:0]  sWriteMask;

    logic        timeoutError, overrunError;

    // Arbiter side: responds to the masters, drives the slave.
    modport slave (
        input  m0Address, m0DataOut, m0WriteEnable, m0WriteMask, m0TransactionBegin,
        input  m1Address, m1DataOut, m1WriteEnable, m1WriteMask, m1TransactionBegin,
        input  sDataIn, sTransactionEnd,
        output m0DataIn, m0TransactionEnd, m1DataIn, m1TransactionEnd,
        output sAddress, sDataOut, sWriteEnable, sWriteMask, sTransactionBegin,
        output timeoutError, overrunError
    );

    // Environment side: the two requesters and the memory port.
    modport master (
        output m0Address, m0DataOut, m0WriteEnable, m0WriteMask, m0TransactionBegin,
        output m1Address, m1DataOut, m1WriteEnable, m1WriteMask, m1TransactionBegin,
        output sDataIn, sTransactionEnd,
        input  m0DataIn, m0TransactionEnd, m1DataIn, m1TransactionEnd,
        input  sAddress, sDataOut, sWriteEnable, sWriteMask, sTransactionBegin,
        input  timeoutError, overrunError
    );

endinterface

// File: rtl/bus_arbiter_slot.sv
// One master's request slot: captures a begin pulse, holds it until served.
module bus_request_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    input  logic [3:0]  mask_i,
    input  logic        clear_i,
    output logic        pending_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic        we_o,
    output logic [3:0]  mask_o,
    output logic        overrun_o
);

    logic        pending_q, pending_d;
    logic        capture;
    logic [31:0] addr_q, data_q;
    logic        we_q;
    logic [3:0]  mask_q;

    always_comb begin
        // A slot that completes on this edge is free to take a new request on it.
        capture   = start_i && (!pending_q || clear_i);
        overrun_o = start_i && pending_q && !clear_i;
        pending_d = pending_q;
        if (capture) begin
            pending_d = 1'b1;
        end else if (clear_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            mask_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (capture) begin
                addr_q <= addr_i;
                data_q <= data_i;
                we_q   <= we_i;
                mask_q <= mask_i;
            end
        end
    end

    assign pending_o = pending_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign we_o      = we_q;
    assign mask_o    = mask_q;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one pulse-begin/pulse-end slave port,
// with a per-transaction watchdog.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_DATA     = ERROR_DATA_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);

    arb_state_e  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [31:0] wdog_q, wdog_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic        m0_end_q, m0_end_d, m1_end_q, m1_end_d;
    logic        tout_q, tout_d, ovr_q, ovr_d;

    logic        sel, issue, done;
    logic [31:0] ret_data;
    logic        p0, p1, ovr0, ovr1;
    logic [31:0] a0, a1, d0, d1;
    logic        we0, we1;
    logic [3:0]  k0, k1;

    bus_request_slot u_slot0 (
        .clk(clk), .rst_n(rst),
        .start_i(bus.m0TransactionBegin), .addr_i(bus.m0Address), .data_i(bus.m0DataOut),
        .we_i(bus.m0WriteEnable), .mask_i(bus.m0WriteMask), .clear_i(done && !grant_q),
        .pending_o(p0), .addr_o(a0), .data_o(d0), .we_o(we0), .mask_o(k0), .overrun_o(ovr0)
    );

    bus_request_slot u_slot1 (
        .clk(clk), .rst_n(rst),
        .start_i(bus.m1TransactionBegin), .addr_i(bus.m1Address), .data_i(bus.m1DataOut),
        .we_i(bus.m1WriteEnable), .mask_i(bus.m1WriteMask), .clear_i(done && grant_q),
        .pending_o(p1), .addr_o(a1), .data_o(d1), .we_o(we1), .mask_o(k1), .overrun_o(ovr1)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        wdog_d     = wdog_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_end_d   = 1'b0;
        m1_end_d   = 1'b0;
        tout_d     = tout_q;
        ovr_d      = ovr_q || ovr0 || ovr1;
        sel        = grant_q;
        issue      = 1'b0;
        done       = 1'b0;
        ret_data   = bus.sDataIn;

        unique case (state_q)
            ST_IDLE: begin
                if (p0 || p1) begin
                    sel     = (p0 && p1) ? !last_q : p1;
                    issue   = 1'b1;
                    grant_d = sel;
                    wdog_d  = TIMEOUT_CYCLES;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Slave response takes priority over a watchdog expiry in the same cycle.
                if (bus.sTransactionEnd) begin
                    done = 1'b1;
                end else if (TIMEOUT_CYCLES != 0 && wdog_q == 32'd1) begin
                    done     = 1'b1;
                    ret_data = ERROR_DATA;
                    tout_d   = 1'b1;
                end else if (wdog_q != '0) begin
                    wdog_d = wdog_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            if (grant_q) begin
                m1_rdata_d = ret_data;
                m1_end_d   = 1'b1;
            end else begin
                m0_rdata_d = ret_data;
                m0_end_d   = 1'b1;
            end
            last_d  = grant_q;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            wdog_q     <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_end_q   <= 1'b0;
            m1_end_q   <= 1'b0;
            tout_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_end_q   <= m0_end_d;
            m1_end_q   <= m1_end_d;
            tout_q     <= tout_d;
            ovr_q      <= ovr_d;
        end
    end

    // Slot fields persist after service, so muxing by the last grant holds the slave bus.
    assign bus.sTransactionBegin = issue;
    assign bus.sAddress          = sel ? a1  : a0;
    assign bus.sDataOut          = sel ? d1  : d0;
    assign bus.sWriteEnable      = sel ? we1 : we0;
    assign bus.sWriteMask        = sel ? k1  : k0;

    assign bus.m0DataIn          = m0_rdata_q;
    assign bus.m1DataIn          = m1_rdata_q;
    assign bus.m0TransactionEnd  = m0_end_q;
    assign bus.m1TransactionEnd  = m1_end_q;
    assign bus.timeoutError      = tout_q;
    assign bus.overrunError      = ovr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (watchdog set to 8 cycles).
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   sbegin_count = 0;
    int   m0_end_count = 0;
    int   m1_end_count = 0;

    bus_arbiter_if bus();

    bus_arbiter #(
        .TIMEOUT_CYCLES(8),
        .ERROR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.sTransactionBegin === 1'b1) sbegin_count++;
        if (bus.m0TransactionEnd === 1'b1) m0_end_count++;
        if (bus.m1TransactionEnd === 1'b1) m1_end_count++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500000 ns, required to finish earlier");
        $fatal(1, "bench time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0Address = '0; bus.m0DataOut = '0; bus.m0WriteEnable = 1'b0;
        bus.m0WriteMask = '0; bus.m0TransactionBegin = 1'b0;
        bus.m1Address = '0; bus.m1DataOut = '0; bus.m1WriteEnable = 1'b0;
        bus.m1WriteMask = '0; bus.m1TransactionBegin = 1'b0;
        bus.sDataIn = '0; bus.sTransactionEnd = 1'b0;
    endtask

    task automatic req(input int m, input logic [31:0] addr, input logic [31:0] data,
                       input logic we, input logic [3:0] mask);
        if (m == 0) begin
            bus.m0Address = addr; bus.m0DataOut = data; bus.m0WriteEnable = we;
            bus.m0WriteMask = mask; bus.m0TransactionBegin = 1'b1;
        end else begin
            bus.m1Address = addr; bus.m1DataOut = data; bus.m1WriteEnable = we;
            bus.m1WriteMask = mask; bus.m1TransactionBegin = 1'b1;
        end
    endtask

    task automatic end_begins();
        bus.m0TransactionBegin = 1'b0;
        bus.m1TransactionBegin = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        bus.sDataIn = d;
        bus.sTransactionEnd = 1'b1;
        tick();
        bus.sTransactionEnd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [68:0] s_grp;
        logic [65:0] m_grp;
        logic [1:0]  e_grp;
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        s_grp = {bus.sAddress, bus.sDataOut, bus.sWriteEnable, bus.sWriteMask};
        m_grp = {bus.m0DataIn, bus.m0TransactionEnd, bus.m1DataIn, bus.m1TransactionEnd};
        e_grp = {bus.timeoutError, bus.overrunError};
        checks++;
        if (s_grp !== '0) begin
            errors++; $display("FAIL reset_slave_fields: got %h required 0", s_grp);
        end
        checks++;
        if (bus.sTransactionBegin !== 1'b0) begin
            errors++; $display("FAIL reset_sbegin: got %b required 0", bus.sTransactionBegin);
        end
        checks++;
        if (m_grp !== '0) begin
            errors++; $display("FAIL reset_master_outputs: got %h required 0", m_grp);
        end
        checks++;
        if (e_grp !== 2'b00) begin
            errors++; $display("FAIL reset_error_flags: got %b required 00", e_grp);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int sb0, e00, e10;
        sb0 = sbegin_count; e00 = m0_end_count; e10 = m1_end_count;
        req(0, 32'h100, 32'h0, 1'b0, WORD_MASK);
        tick();
        end_begins();
        checks++;
        if (bus.sTransactionBegin !== 1'b1 || bus.sAddress !== 32'h100 || bus.sWriteEnable !== 1'b0) begin
            errors++; $display("FAIL single_issue: begin=%b addr=%h we=%b required 1/00000100/0",
                               bus.sTransactionBegin, bus.sAddress, bus.sWriteEnable);
        end
        tick();
        checks++;
        if (bus.sTransactionBegin !== 1'b0) begin
            errors++; $display("FAIL single_begin_one_cycle: got %b required 0", bus.sTransactionBegin);
        end
        tick();
        tick();
        respond(32'h12345678);
        checks++;
        if (bus.m0TransactionEnd !== 1'b1 || bus.m0DataIn !== 32'h12345678) begin
            errors++; $display("FAIL single_m0_end: end=%b data=%h required 1/12345678",
                               bus.m0TransactionEnd, bus.m0DataIn);
        end
        checks++;
        if (bus.m1TransactionEnd !== 1'b0 || bus.m1DataIn !== 32'h0) begin
            errors++; $display("FAIL single_m1_quiet: end=%b data=%h required 0/00000000",
                               bus.m1TransactionEnd, bus.m1DataIn);
        end
        tick();
        checks++;
        if (bus.m0TransactionEnd !== 1'b0 || bus.m0DataIn !== 32'h12345678) begin
            errors++; $display("FAIL single_m0_hold: end=%b data=%h required 0/12345678",
                               bus.m0TransactionEnd, bus.m0DataIn);
        end
        checks++;
        if (sbegin_count - sb0 != 1 || m0_end_count - e00 != 1 || m1_end_count - e10 != 0) begin
            errors++; $display("FAIL single_pulse_counts: sbegin=%0d m0end=%0d m1end=%0d required 1/1/0",
                               sbegin_count - sb0, m0_end_count - e00, m1_end_count - e10);
        end
    endtask

    task automatic test_tie();
        do_reset();
        req(0, 32'h0, 32'h0, 1'b0, WORD_MASK);
        req(1, 32'h40, 32'hA5A5A5A5, 1'b1, WORD_MASK);
        tick();
        end_begins();
        checks++;
        if (bus.sTransactionBegin !== 1'b1 || bus.sAddress !== 32'h0 || bus.sWriteEnable !== 1'b0) begin
            errors++; $display("FAIL tie1_m0_first: begin=%b addr=%h we=%b required 1/00000000/0",
                               bus.sTransactionBegin, bus.sAddress, bus.sWriteEnable);
        end
        tick();
        respond(32'h11111111);
        checks++;
        if (bus.m0TransactionEnd !== 1'b1 || bus.m0DataIn !== 32'h11111111) begin
            errors++; $display("FAIL tie1_m0_end: end=%b data=%h required 1/11111111",
                               bus.m0TransactionEnd, bus.m0DataIn);
        end
        checks++;
        if (bus.sTransactionBegin !== 1'b1 || bus.sAddress !== 32'h40 || bus.sDataOut !== 32'hA5A5A5A5 ||
            bus.sWriteEnable !== 1'b1 || bus.sWriteMask !== 4'hF) begin
            errors++; $display("FAIL tie1_m1_issue: begin=%b addr=%h data=%h we=%b mask=%h required 1/00000040/a5a5a5a5/1/f",
                               bus.sTransactionBegin, bus.sAddress, bus.sDataOut, bus.sWriteEnable, bus.sWriteMask);
        end
        tick();
        respond(32'h0);
        checks++;
        if (bus.m1TransactionEnd !== 1'b1 || bus.m0TransactionEnd !== 1'b0) begin
            errors++; $display("FAIL tie1_m1_end: m1end=%b m0end=%b required 1/0",
                               bus.m1TransactionEnd, bus.m0TransactionEnd);
        end
        tick();
        // m0 served last, so the next tie goes to m1.
        req(0, 32'h10, 32'h0, 1'b0, WORD_MASK);
        tick();
        end_begins();
        tick();
        respond(32'h22222222);
        checks++;
        if (bus.m0TransactionEnd !== 1'b1 || bus.m0DataIn !== 32'h22222222) begin
            errors++; $display("FAIL tie_mid_m0_end: end=%b data=%h required 1/22222222",
                               bus.m0TransactionEnd, bus.m0DataIn);
        end
        tick();
        req(0, 32'h20, 32'h0, 1'b0, HALF_MASK);
        req(1, 32'h44, 32'h0, 1'b0, WORD_MASK);
        tick();
        end_begins();
        checks++;
        if (bus.sTransactionBegin !== 1'b1 || bus.sAddress !== 32'h44) begin
            errors++; $display("FAIL tie2_m1_first: begin=%b addr=%h required 1/00000044",
                               bus.sTransactionBegin, bus.sAddress);
        end
        tick();
        respond(32'h33333333);
        checks++;
        if (bus.m1TransactionEnd !== 1'b1 || bus.m1DataIn !== 32'h33333333 ||
            bus.sAddress !== 32'h20 || bus.sWriteMask !== HALF_MASK) begin
            errors++; $display("FAIL tie2_m1_end_m0_issue: m1end=%b m1data=%h addr=%h mask=%h required 1/33333333/00000020/3",
                               bus.m1TransactionEnd, bus.m1DataIn, bus.sAddress, bus.sWriteMask);
        end
        tick();
        respond(32'h44444444);
        checks++;
        if (bus.m0TransactionEnd !== 1'b1 || bus.m0DataIn !== 32'h44444444 || bus.m1DataIn !== 32'h33333333) begin
            errors++; $display("FAIL tie2_m0_end: end=%b data=%h m1data=%h required 1/44444444/33333333",
                               bus.m0TransactionEnd, bus.m0DataIn, bus.m1DataIn);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        req(0, 32'h200, 32'h0, 1'b0, WORD_MASK);
        tick();
        end_begins();
        tick();
        req(1, 32'h300, 32'h000000AB, 1'b1, BYTE_MASK);
        tick();
        end_begins();
        checks++;
        if (bus.sTransactionBegin !== 1'b0 || bus.sAddress !== 32'h200) begin
            errors++; $display("FAIL b2b_wait_hold: begin=%b addr=%h required 0/00000200",
                               bus.sTransactionBegin, bus.sAddress);
        end
        respond(32'hCAFEF00D);
        checks++;
        if (bus.m0TransactionEnd !== 1'b1 || bus.m0DataIn !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b_m0_end: end=%b data=%h required 1/cafef00d",
                               bus.m0TransactionEnd, bus.m0DataIn);
        end
        checks++;
        if (bus.sTransactionBegin !== 1'b1 || bus.sAddress !== 32'h300 || bus.sDataOut !== 32'hAB ||
            bus.sWriteEnable !== 1'b1 || bus.sWriteMask !== 4'd1) begin
            errors++; $display("FAIL b2b_m1_issue: begin=%b addr=%h data=%h we=%b mask=%h required 1/00000300/000000ab/1/1",
                               bus.sTransactionBegin, bus.sAddress, bus.sDataOut, bus.sWriteEnable, bus.sWriteMask);
        end
        tick();
        respond(32'h0);
        checks++;
        if (bus.m1TransactionEnd !== 1'b1 || bus.m1DataIn !== 32'h0) begin
            errors++; $display("FAIL b2b_m1_end: end=%b data=%h required 1/00000000",
                               bus.m1TransactionEnd, bus.m1DataIn);
        end
        tick();
    endtask

    task automatic test_timeout();
        req(0, 32'h500, 32'h0, 1'b0, WORD_MASK);
        tick();
        end_begins();
        tick();
        repeat (7) tick();
        checks++;
        if (bus.m0TransactionEnd !== 1'b0 || bus.timeoutError !== 1'b0) begin
            errors++; $display("FAIL timeout_early: end=%b tout=%b after 7 wait cycles required 0/0",
                               bus.m0TransactionEnd, bus.timeoutError);
        end
        tick();
        checks++;
        if (bus.m0TransactionEnd !== 1'b1 || bus.m0DataIn !== 32'hDEADBEEF || bus.timeoutError !== 1'b1) begin
            errors++; $display("FAIL timeout_fire: end=%b data=%h tout=%b required 1/deadbeef/1",
                               bus.m0TransactionEnd, bus.m0DataIn, bus.timeoutError);
        end
        respond(32'h77777777);
        checks++;
        if (bus.m0TransactionEnd !== 1'b0 || bus.m0DataIn !== 32'hDEADBEEF ||
            bus.sTransactionBegin !== 1'b0 || bus.timeoutError !== 1'b1) begin
            errors++; $display("FAIL timeout_late_end: end=%b data=%h sbegin=%b tout=%b required 0/deadbeef/0/1",
                               bus.m0TransactionEnd, bus.m0DataIn, bus.sTransactionBegin, bus.timeoutError);
        end
        tick();
    endtask

    task automatic test_overrun();
        int sb0;
        do_reset();
        sb0 = sbegin_count;
        req(0, 32'h600, 32'h0, 1'b0, WORD_MASK);
        tick();
        checks++;
        if (bus.overrunError !== 1'b0 || bus.sAddress !== 32'h600) begin
            errors++; $display("FAIL overrun_before: ovr=%b addr=%h required 0/00000600",
                               bus.overrunError, bus.sAddress);
        end
        req(0, 32'h700, 32'h0, 1'b0, WORD_MASK);
        tick();
        checks++;
        if (bus.overrunError !== 1'b1) begin
            errors++; $display("FAIL overrun_set: got %b required 1", bus.overrunError);
        end
        req(0, 32'h800, 32'h0, 1'b0, WORD_MASK);
        tick();
        end_begins();
        respond(32'h55555555);
        checks++;
        if (bus.m0TransactionEnd !== 1'b1 || bus.m0DataIn !== 32'h55555555) begin
            errors++; $display("FAIL overrun_first_served: end=%b data=%h required 1/55555555",
                               bus.m0TransactionEnd, bus.m0DataIn);
        end
        repeat (3) tick();
        checks++;
        if (sbegin_count - sb0 != 1 || bus.sAddress !== 32'h600 || bus.overrunError !== 1'b1) begin
            errors++; $display("FAIL overrun_dropped: sbegins=%0d addr=%h ovr=%b required 1/00000600/1",
                               sbegin_count - sb0, bus.sAddress, bus.overrunError);
        end
    endtask

    task automatic test_reset_mid();
        int e00, e10, sb0;
        logic [139:0] all_out;
        req(0, 32'h900, 32'h0, 1'b0, WORD_MASK);
        tick();
        end_begins();
        tick();
        req(1, 32'hA00, 32'h0, 1'b0, WORD_MASK);
        tick();
        end_begins();
        #2 rst = 1'b0;
        #1;
        all_out = {bus.sAddress, bus.sDataOut, bus.sWriteEnable, bus.sWriteMask, bus.sTransactionBegin,
                   bus.m0DataIn, bus.m0TransactionEnd, bus.m1DataIn, bus.m1TransactionEnd,
                   bus.timeoutError, bus.overrunError};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got %h required 0", all_out);
        end
        e00 = m0_end_count; e10 = m1_end_count;
        bus.sDataIn = 32'h99999999;
        bus.sTransactionEnd = 1'b1;
        tick();
        bus.sTransactionEnd = 1'b0;
        tick();
        rst = 1'b1;
        sb0 = sbegin_count;
        repeat (3) tick();
        checks++;
        if (m0_end_count != e00 || m1_end_count != e10 || sbegin_count != sb0) begin
            errors++; $display("FAIL rstmid_no_pulses: m0end=%0d m1end=%0d sbegin=%0d required 0/0/0",
                               m0_end_count - e00, m1_end_count - e10, sbegin_count - sb0);
        end
        req(1, 32'hB00, 32'h0, 1'b0, WORD_MASK);
        tick();
        end_begins();
        checks++;
        if (bus.sTransactionBegin !== 1'b1 || bus.sAddress !== 32'hB00) begin
            errors++; $display("FAIL rstmid_new_issue: begin=%b addr=%h required 1/00000b00",
                               bus.sTransactionBegin, bus.sAddress);
        end
        tick();
        tick();
        respond(32'h66666666);
        checks++;
        if (bus.m1TransactionEnd !== 1'b1 || bus.m1DataIn !== 32'h66666666 || bus.m0DataIn !== 32'h0) begin
            errors++; $display("FAIL rstmid_new_end: end=%b data=%h m0data=%h required 1/66666666/00000000",
                               bus.m1TransactionEnd, bus.m1DataIn, bus.m0DataIn);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
